// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver with frame-synchronous double buffering,
// programmable digit-slot prescaler and optional leading-zero blanking.
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int HEX_MODE   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [PW-1:0]             presc_q, presc_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic                      started_q, started_d;
    logic [4*NUM_DIGITS-1:0]   pend_code_q, pend_code_d;
    logic [NUM_DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic                      pend_valid_q, pend_valid_d;
    logic [4*NUM_DIGITS-1:0]   disp_code_q, disp_code_d;
    logic [NUM_DIGITS-1:0]     disp_dp_q, disp_dp_d;
    logic [6:0]                seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;
    logic                      frame_done_q, frame_done_d;

    logic                      tick;
    logic                      boundary;
    logic [IW-1:0]             next_idx;
    logic [3:0]                cur_code;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110010;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            4'd10:   s = (HEX_MODE != 0) ? 7'b1110111 : 7'b0000000;
            4'd11:   s = (HEX_MODE != 0) ? 7'b0011111 : 7'b0000000;
            4'd12:   s = (HEX_MODE != 0) ? 7'b1001110 : 7'b0000000;
            4'd13:   s = (HEX_MODE != 0) ? 7'b0111101 : 7'b0000000;
            4'd14:   s = (HEX_MODE != 0) ? 7'b1001111 : 7'b0000000;
            default: s = (HEX_MODE != 0) ? 7'b1000111 : 7'b0000000;
        endcase
        return s;
    endfunction

    // A digit is a leading zero when it and every more-significant digit is 0.
    function automatic logic is_leading_zero(input logic [4*NUM_DIGITS-1:0] codes,
                                             input logic [IW-1:0] k);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(k) && codes[4*j +: 4] != 4'd0)
                upper_zero = 1'b0;
        end
        return (k != '0) && upper_zero;
    endfunction

    always_comb begin
        tick    = (presc_q == PW'(CLK_DIV - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);

        // The first tick after reset starts the scan at digit 0.
        if (!started_q || idx_q == IW'(NUM_DIGITS - 1))
            next_idx = '0;
        else
            next_idx = idx_q + IW'(1);

        boundary  = tick && (next_idx == '0);
        idx_d     = tick ? next_idx : idx_q;
        started_d = started_q | tick;

        disp_code_d = (boundary && pend_valid_q) ? pend_code_q : disp_code_q;
        disp_dp_d   = (boundary && pend_valid_q) ? pend_dp_q   : disp_dp_q;

        pend_code_d = load ? bcd_in : pend_code_q;
        pend_dp_d   = load ? dp_in  : pend_dp_q;
        if (load)
            pend_valid_d = 1'b1;
        else if (boundary)
            pend_valid_d = 1'b0;
        else
            pend_valid_d = pend_valid_q;

        cur_code = disp_code_d[{next_idx, 2'b00} +: 4];
        seg_d    = seg_q;
        dp_d     = dp_q;
        an_d     = an_q;
        if (tick) begin
            seg_d = (blank_lz && is_leading_zero(disp_code_d, next_idx)) ? 7'b0000000
                                                                        : decode(cur_code);
            dp_d  = disp_dp_d[next_idx];
            an_d  = NUM_DIGITS'(1) << next_idx;
        end
        frame_done_d = boundary;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            started_q    <= 1'b0;
            pend_code_q  <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            disp_code_q  <= '0;
            disp_dp_q    <= '0;
            seg_q        <= '0;
            dp_q         <= 1'b0;
            an_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            started_q    <= started_d;
            pend_code_q  <= pend_code_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            disp_code_q  <= disp_code_d;
            disp_dp_q    <= disp_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a frame-level reference model checked every cycle
// on a decimal-mode and a hex-mode instance, plus literal digit expectations.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int CD = 4;

    localparam logic [6:0] SEG_DEC [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
        7'b1011111, 7'b1110010, 7'b1111111, 7'b1111011,
        7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
    localparam logic [6:0] SEG_HEX [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
        7'b1011111, 7'b1110010, 7'b1111111, 7'b1111011,
        7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;
    logic [3:0]  an0, an1;
    logic        fd0, fd1;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD), .HEX_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .seg(seg0), .dp(dp0), .an(an0), .frame_done(fd0));

    seg7_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD), .HEX_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .seg(seg1), .dp(dp1), .an(an1), .frame_done(fd1));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time is counted in clock edges since reset release.
    int          m_edge;
    logic [15:0] m_pend_code, m_disp_code;
    logic [3:0]  m_pend_dp, m_disp_dp;
    bit          m_pend_valid;
    logic [6:0]  m_seg_dec, m_seg_hex;
    logic        m_dp;
    logic [3:0]  m_an;
    logic        m_fd;

    task automatic model_reset();
        m_edge = 0;
        m_pend_code = '0; m_disp_code = '0;
        m_pend_dp = '0;   m_disp_dp = '0;
        m_pend_valid = 0;
        m_seg_dec = '0; m_seg_hex = '0; m_dp = 1'b0; m_an = '0; m_fd = 1'b0;
    endtask

    task automatic model_step();
        bit  is_tick, is_bnd, lz;
        int  digit;
        logic [3:0] code;
        is_tick = (m_edge % CD) == CD - 1;
        digit   = (m_edge / CD) % ND;
        is_bnd  = is_tick && digit == 0;
        m_fd    = is_bnd;
        if (is_bnd && m_pend_valid) begin
            m_disp_code = m_pend_code;
            m_disp_dp   = m_pend_dp;
        end
        if (is_bnd) m_pend_valid = 0;
        if (load) begin
            m_pend_code  = bcd_in;
            m_pend_dp    = dp_in;
            m_pend_valid = 1;
        end
        if (is_tick) begin
            code = m_disp_code[4*digit +: 4];
            lz   = blank_lz && digit >= 1 && (m_disp_code >> (4*digit)) == 16'd0;
            m_seg_dec = lz ? 7'd0 : SEG_DEC[code];
            m_seg_hex = lz ? 7'd0 : SEG_HEX[code];
            m_dp      = m_disp_dp[digit];
            m_an      = 4'b0001 << digit;
        end
        m_edge++;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
            #1;
            chk("seg_dec", 32'(seg0), 32'(m_seg_dec));
            chk("seg_hex", 32'(seg1), 32'(m_seg_hex));
            chk("an",      32'({an1, an0}), 32'({m_an, m_an}));
            chk("dp",      32'({dp1, dp0}), 32'({m_dp, m_dp}));
            chk("frame_done", 32'({fd1, fd0}), 32'({m_fd, m_fd}));
        end
    end

    task automatic wait_frame();
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (fd0 === 1'b1) seen = 1;
        end
        chk("frame_timeout", 32'(seen), 32'd1);
    endtask

    task automatic wait_digit(input int d);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (an0 === (4'b0001 << d)) seen = 1;
        end
        chk("digit_timeout", 32'(seen), 32'd1);
    endtask

    task automatic do_load(input logic [15:0] code, input logic [3:0] dps);
        bcd_in = code; dp_in = dps; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; bcd_in = '0; dp_in = '0; blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Blank until first tick, then digit 0 showing zero with a frame pulse.
        repeat (3) begin
            @(negedge clk);
            chk("blank_an", 32'(an0), 32'd0);
            chk("blank_seg", 32'(seg0), 32'd0);
        end
        @(negedge clk);
        chk("first_an", 32'(an0), 32'b0001);
        chk("first_seg", 32'(seg0), 32'b1111110);
        chk("first_fd", 32'(fd0), 32'd1);

        // Mid-frame load of 1234 with dp on digit 2.
        repeat (5) @(negedge clk);
        do_load(16'h1234, 4'b0100);
        wait_frame();
        chk("d0_4", 32'({seg0, dp0}), 32'({7'b0110011, 1'b0}));
        wait_digit(1); chk("d1_3", 32'({seg0, dp0}), 32'({7'b1111001, 1'b0}));
        wait_digit(2); chk("d2_2", 32'({seg0, dp0}), 32'({7'b1101101, 1'b1}));
        wait_digit(3); chk("d3_1", 32'({seg0, dp0}), 32'({7'b0110000, 1'b0}));

        // Leading-zero blanking on 0050, then blanking turned off live.
        blank_lz = 1'b1;
        do_load(16'h0050, 4'b0000);
        wait_frame();
        chk("lz_d0", 32'(seg0), 32'b1111110);
        wait_digit(1); chk("lz_d1", 32'(seg0), 32'b1011011);
        wait_digit(2); chk("lz_d2", 32'(seg0), 32'b0000000);
        wait_digit(3); chk("lz_d3", 32'(seg0), 32'b0000000);
        blank_lz = 1'b0;
        wait_frame();
        wait_digit(2); chk("nolz_d2", 32'(seg0), 32'b1111110);
        wait_digit(3); chk("nolz_d3", 32'(seg0), 32'b1111110);

        // Code B: blank in decimal mode, 'b' in hex mode.
        do_load(16'h000B, 4'b0000);
        wait_frame();
        chk("b_dec", 32'(seg0), 32'b0000000);
        chk("b_hex", 32'(seg1), 32'b0011111);

        // Load landing exactly on a boundary edge with nothing pending.
        repeat (15) @(negedge clk);
        bcd_in = 16'h0007; dp_in = 4'b0000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("coinc_fd", 32'(fd0), 32'd1);
        chk("coinc_old_dec", 32'(seg0), 32'b0000000);
        chk("coinc_old_hex", 32'(seg1), 32'b0011111);
        wait_frame();
        chk("coinc_new", 32'(seg0), 32'b1110010);

        // Two loads in one frame: the last one wins.
        repeat (2) @(negedge clk);
        do_load(16'h1111, 4'b0000);
        repeat (3) @(negedge clk);
        do_load(16'h2222, 4'b0000);
        wait_frame();
        chk("last_d0", 32'(seg0), 32'b1101101);
        for (int d = 1; d < ND; d++) begin
            wait_digit(d);
            chk("last_dn", 32'(seg0), 32'b1101101);
        end

        // Asynchronous reset mid-scan discards a pending load.
        do_load(16'h0009, 4'b0000);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_an", 32'(an0), 32'd0);
        chk("rst_seg", 32'(seg0), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            wait_frame();
            chk("post_rst_d0", 32'(seg0), 32'b1111110);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised multi-digit, time-multiplexed 7-segment display driver. It accepts NUM_DIGITS packed 4-bit digit codes plus per-digit decimal points, and double-buffers them so that updates take effect only at frame boundaries (no tearing). It scans the digits with a programmable prescaler and drives one shared segment bus plus one-hot digit enables. It sits between the counter/BCD datapath and the board display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (>=2); digit 0 = least significant.
CLK_DIV, 50000, clk cycles per digit slot (>=2).
HEX_MODE, 0, 0 = codes 10-15 blank the digit; 1 = codes 10-15 display A,b,C,d,E,F.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
bcd_in  input  4*NUM_DIGITS  packed digit codes; digit k = bcd_in[4k+3:4k].
dp_in  input  NUM_DIGITS  decimal point request per digit, active-high.
load  input  1  one-cycle strobe: capture bcd_in/dp_in into the pending buffer.
blank_lz  input  1  1 = suppress leading zeros.
seg  output  7  segments {a,b,c,d,e,f,g}, seg[6]=a, active-high.
dp  output  1  decimal point of the active digit, active-high.
an  output  NUM_DIGITS  one-hot digit enable, active-high.
frame_done  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (async, active-high): prescaler=0, idx=0, pending=0, pend_valid=0, display=0, seg=0, dp=0, an=0, frame_done=0. All outputs stay blank until the first tick.
- Prescaler: counts 0..CLK_DIV-1 and wraps. A tick is asserted in the cycle it equals CLK_DIV-1.
- On a tick edge, next_idx = idx+1, wrapping NUM_DIGITS-1 -> 0. Digit period = CLK_DIV cycles. Frame = NUM_DIGITS*CLK_DIV cycles.
- Frame boundary = a tick with next_idx=0. On that edge:
  - If pend_valid=1: display <= pending, and pend_valid is cleared.
  - frame_done = 1 for exactly that following cycle.
- load: pending <= {bcd_in, dp_in} and pend_valid <= 1.
  - Load has priority over the boundary clear of pend_valid.
  - If load coincides with a boundary, display takes the pre-load pending contents (only if pend_valid was 1). The new data commits at the next boundary.
  - Repeated loads within one frame: the last one wins.
- Outputs are registered and change only on tick edges:
  - an <= one-hot(next_idx).
  - seg, dp <= decode of display_next[next_idx], where display_next is the value committed on that same edge.
  - The newly committed data is therefore visible from digit 0 of the new frame.
- Decode (seg a..g):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110010, 8=1111111, 9=1111011.
  - Codes 10-15 with HEX_MODE=0: 0000000.
  - Codes 10-15 with HEX_MODE=1: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Leading-zero blanking: digit k (k>=1) shows seg=0000000 when blank_lz=1, its code is 0, and all digits above k are 0.
  - Digit 0 is never blanked.
  - dp is never blanked.
  - blank_lz is sampled live, not buffered.
- Reset mid-frame: everything returns immediately to reset values; the pending load is discarded.

Test Plan:
- Bench setup: NUM_DIGITS=4, CLK_DIV=4.
- Reset release, no load -> an=0000 and seg=0 for cycles 0-3. First tick edge gives an=0001, seg=1111110 (display=0). an then rotates 0010, 0100, 1000, 0001 every 4 cycles. frame_done pulses once every 16 cycles.
- load bcd_in=16'h1234, dp_in=4'b0100 mid-frame -> no change until the next boundary. Then digit0 seg=0110011(4), digit1=1111001(3), digit2=1101101(2) with dp=1, digit3=0110000(1).
- bcd_in=16'h0050, blank_lz=1 -> digit3 and digit2 seg=0, digit1=1011011, digit0=1111110. With blank_lz=0, digits 3 and 2 show 1111110.
- Code 4'hB with HEX_MODE=0 -> seg=0000000. With HEX_MODE=1 -> seg=0011111.
- load coincident with a boundary tick while pend_valid=0 -> display unchanged for that frame. New value appears at the following boundary. load of 16'h1111 then 16'h2222 in the same frame -> only 2222 is ever shown.
- rst asserted mid-scan with a pending load -> outputs go to 0 asynchronously. After release, 0000 is displayed; the pending data never appears.
